// File: rtl/l2_responder.sv
// L2 responder: line-organised backing store (8 x 32-bit words per line)
// serving level-held L1 read requests and 8-beat write bursts. Each request
// that completes is closed with a single-cycle l2_ack pulse. Outputs are
// registered so that no input reaches an output combinationally.
module l2_responder #(
  parameter int READ_LATENCY = 4,
  parameter int LINE_AW      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_l2,
  input  logic        write_l2,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        l2_ack,
  output logic        busy
);

  localparam int LAT_W   = $clog2(READ_LATENCY + 1);
  localparam int WORDS   = (1 << LINE_AW) * 8;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [LAT_W-1:0] LAT_ONE  = LAT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_WAIT  = 3'd1,
    RD_BURST = 3'd2,
    WR_BURST = 3'd3,
    ACK      = 3'd4,
    GAP      = 3'd5
  } state_t;

  state_t               state_r;
  logic [LINE_AW-1:0]   line_r;
  logic [LAT_W-1:0]     lat_cnt_r;
  logic [2:0]           beat_r;
  logic [31:0]          rdata_r;
  logic                 rdata_valid_r;
  logic                 l2_ack_r;
  logic                 busy_r;

  // Backing store is deliberately left out of reset: contents survive reset.
  logic [31:0]          store_r [0:WORDS-1];

  logic                 wr_en_s;
  logic [LINE_AW+2:0]   wr_idx_s;
  logic [LINE_AW+2:0]   rd_idx_s;
  logic [2:0]           beat_nxt_s;

  // Store write strobe and the address of the word to present on the next beat.
  always_comb begin
    wr_en_s    = 1'b0;
    wr_idx_s   = {line_r, beat_r};
    beat_nxt_s = beat_r + 3'd1;
    rd_idx_s   = {line_r, 3'd0};
    if (state_r == WR_BURST) begin
      wr_en_s = write_l2;
    end else begin
      wr_en_s = 1'b0;
    end
    if (state_r == RD_BURST) begin
      rd_idx_s = {line_r, beat_nxt_s};
    end else begin
      rd_idx_s = {line_r, 3'd0};
    end
  end

  // Write one burst beat into the store per cycle while the write request holds.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      store_r[wr_idx_s] <= wdata;
    end
  end

  // Request sequencer with registered outputs; a dropped request returns to IDLE unacknowledged.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      line_r        <= '0;
      lat_cnt_r     <= '0;
      beat_r        <= 3'd0;
      rdata_r       <= 32'd0;
      rdata_valid_r <= 1'b0;
      l2_ack_r      <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      l2_ack_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (read_l2) begin
            line_r    <= addr[LINE_AW+4:5];
            lat_cnt_r <= '0;
            busy_r    <= 1'b1;
            state_r   <= RD_WAIT;
          end else if (write_l2) begin
            line_r  <= addr[LINE_AW+4:5];
            beat_r  <= 3'd0;
            busy_r  <= 1'b1;
            state_r <= WR_BURST;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        RD_WAIT: begin
          if (!read_l2) begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (lat_cnt_r == LAT_LAST) begin
            beat_r        <= 3'd0;
            rdata_r       <= store_r[rd_idx_s];
            rdata_valid_r <= 1'b1;
            state_r       <= RD_BURST;
          end else begin
            lat_cnt_r <= lat_cnt_r + LAT_ONE;
          end
        end
        RD_BURST: begin
          if (!read_l2) begin
            beat_r        <= 3'd0;
            rdata_r       <= 32'd0;
            rdata_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            state_r       <= IDLE;
          end else if (beat_r == 3'd7) begin
            beat_r        <= 3'd0;
            rdata_r       <= 32'd0;
            rdata_valid_r <= 1'b0;
            l2_ack_r      <= 1'b1;
            state_r       <= ACK;
          end else begin
            beat_r  <= beat_nxt_s;
            rdata_r <= store_r[rd_idx_s];
          end
        end
        WR_BURST: begin
          if (!write_l2) begin
            beat_r  <= 3'd0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end else if (beat_r == 3'd7) begin
            beat_r   <= 3'd0;
            l2_ack_r <= 1'b1;
            state_r  <= ACK;
          end else begin
            beat_r <= beat_nxt_s;
          end
        end
        ACK: begin
          state_r <= GAP;
        end
        GAP: begin
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          beat_r        <= 3'd0;
          lat_cnt_r     <= '0;
          rdata_r       <= 32'd0;
          rdata_valid_r <= 1'b0;
          busy_r        <= 1'b0;
          state_r       <= IDLE;
        end
      endcase
    end
  end

  assign rdata       = rdata_r;
  assign rdata_valid = rdata_valid_r;
  assign l2_ack      = l2_ack_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_l2_responder.sv
// Bench for l2_responder: directed scenarios followed by randomized traffic.
// Expected per-cycle outputs are derived from the transaction timing rules
// (acceptance edge plus fixed offsets) and a word-array model of the store.
module tb_l2_responder;

  localparam int L  = 4;
  localparam int NC = 16384;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        read_l2 = 1'b0;
  logic        write_l2 = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        l2_ack;
  logic        busy;

  l2_responder #(.READ_LATENCY(L), .LINE_AW(6)) dut (
    .clk(clk), .reset(reset), .read_l2(read_l2), .write_l2(write_l2),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .l2_ack(l2_ack), .busy(busy)
  );

  always #5 clk = ~clk;

  // Cycle index: value seen at a falling edge equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit          exp_busy  [NC];
  bit          exp_valid [NC];
  bit          exp_ack   [NC];
  logic [31:0] exp_data  [NC];
  logic [31:0] mdl [512];
  logic [31:0] wbuf [8];

  int checks = 0;
  int failures = 0;
  int next_ok = 0;
  bit mon_en = 1'b0;
  int busy_cnt = 0, valid_cnt = 0, ack_cnt = 0, last_ack_idx = -1;
  logic [31:0] rd_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, req);
    end
  endtask

  // Per-cycle comparison of every output against the scheduled expectation.
  always @(negedge clk) begin
    if (mon_en && !reset && cyc < NC) begin
      chk("busy", {31'd0, busy}, {31'd0, exp_busy[cyc]});
      chk("rdata_valid", {31'd0, rdata_valid}, {31'd0, exp_valid[cyc]});
      chk("l2_ack", {31'd0, l2_ack}, {31'd0, exp_ack[cyc]});
      if (exp_valid[cyc]) chk("rdata", rdata, exp_data[cyc]);
      if (busy) busy_cnt++;
      if (rdata_valid) begin
        valid_cnt++;
        rd_log.push_back(rdata);
      end
      if (l2_ack) begin
        ack_cnt++;
        last_ack_idx = cyc;
      end
    end
  end

  function automatic logic [31:0] mk_addr(input int line);
    logic [31:0] a;
    logic [5:0]  l6;
    a = $urandom;
    l6 = line[5:0];
    a[10:5] = l6;
    return a;
  endfunction

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_valid"}, {31'd0, rdata_valid}, 32'd0);
    chk({tag, "_ack"}, {31'd0, l2_ack}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Write burst of wbuf to a line; nb<8 ends after nb stored beats, by drop or by reset pulse.
  task automatic do_write(input int line, input int nb, input bit rst_mid, output int e0);
    int last;
    while (cyc + 1 < next_ok) @(negedge clk);
    addr = mk_addr(line);
    read_l2 = 1'b0;
    write_l2 = 1'b1;
    e0 = cyc + 1;
    last = (nb == 8) ? 9 : nb;
    for (int i = 0; i <= last; i++) exp_busy[e0 + i] = 1'b1;
    if (nb == 8) exp_ack[e0 + 8] = 1'b1;
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      wdata = wbuf[k];
      mdl[line * 8 + k] = wbuf[k];
    end
    @(negedge clk);
    if (nb == 8) begin
      write_l2 = 1'b0;
      next_ok = e0 + 11;
    end else if (rst_mid) begin
      wdata = wbuf[nb];
      #2 reset = 1'b1;
      write_l2 = 1'b0;
      #1 chk_zero_outputs("rst_wr");
      #1 reset = 1'b0;
      next_ok = e0 + nb + 2;
    end else begin
      write_l2 = 1'b0;
      next_ok = e0 + nb + 2;
    end
    while (cyc < next_ok - 1) @(negedge clk);
  endtask

  // Read a line; cut<0 runs to completion, else the read ends in cycle index e0+cut.
  task automatic do_read(input int line, input bit both, input int cut, input bit rst_mid, output int e0);
    int last;
    while (cyc + 1 < next_ok) @(negedge clk);
    addr = mk_addr(line);
    wdata = $urandom;
    read_l2 = 1'b1;
    write_l2 = both;
    e0 = cyc + 1;
    last = (cut < 0) ? L + 9 : cut;
    for (int i = 0; i <= last; i++) exp_busy[e0 + i] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (cut < 0 || L + k <= cut) begin
        exp_valid[e0 + L + k] = 1'b1;
        exp_data[e0 + L + k]  = mdl[line * 8 + k];
      end
    end
    if (cut < 0) begin
      exp_ack[e0 + L + 8] = 1'b1;
      while (cyc < e0 + L + 8) @(negedge clk);
      read_l2 = 1'b0;
      write_l2 = 1'b0;
      next_ok = e0 + L + 11;
    end else begin
      while (cyc < e0 + cut) @(negedge clk);
      if (rst_mid) begin
        #2 reset = 1'b1;
        read_l2 = 1'b0;
        write_l2 = 1'b0;
        #1 chk_zero_outputs("rst_rd");
        #1 reset = 1'b0;
      end else begin
        read_l2 = 1'b0;
        write_l2 = 1'b0;
      end
      next_ok = e0 + cut + 2;
    end
    while (cyc < next_ok - 1) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, b0, a0, v0, op, r, line;
    for (int i = 0; i < NC; i++) begin
      exp_busy[i] = 1'b0;
      exp_valid[i] = 1'b0;
      exp_ack[i] = 1'b0;
      exp_data[i] = 32'd0;
    end
    for (int i = 0; i < 512; i++) mdl[i] = 32'd0;

    #1 reset = 1'b1;
    #2 chk_zero_outputs("reset");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    mon_en = 1'b1;
    next_ok = cyc + 1;

    // Give the lines used below known contents.
    for (int l = 0; l < 9; l++) begin
      for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
      do_write((l == 8) ? 63 : l, 8, 1'b0, e0);
    end

    // Full write burst to line 3.
    for (int k = 0; k < 8; k++) wbuf[k] = 32'hA0 + k;
    b0 = busy_cnt; a0 = ack_cnt;
    do_write(3, 8, 1'b0, e0);
    @(negedge clk); #1;
    chk("wr_busy_cycles", busy_cnt - b0, 32'd10);
    chk("wr_ack_count", ack_cnt - a0, 32'd1);
    chk("wr_ack_cycle", last_ack_idx, e0 + 8);

    // Read back line 3.
    rd_log.delete();
    do_read(3, 1'b0, -1, 1'b0, e0);
    @(negedge clk); #1;
    chk("rd_beats", rd_log.size(), 32'd8);
    for (int k = 0; k < 8; k++) chk("rd_word", (k < rd_log.size()) ? rd_log[k] : 32'hDEAD_BEEF, 32'hA0 + k);
    chk("rd_ack_cycle", last_ack_idx, e0 + L + 8);

    // Simultaneous request: the read is served, the write leaves no trace.
    a0 = ack_cnt;
    do_read(2, 1'b1, -1, 1'b0, e0);
    do_read(2, 1'b0, -1, 1'b0, e0);
    @(negedge clk); #1;
    chk("simul_acks", ack_cnt - a0, 32'd2);

    // Read abort in RD_WAIT.
    v0 = valid_cnt; a0 = ack_cnt;
    do_read(3, 1'b0, 1, 1'b0, e0);
    @(negedge clk); #1;
    chk("abort_valid", valid_cnt - v0, 32'd0);
    chk("abort_ack", ack_cnt - a0, 32'd0);

    // Reset during write beat 4 to line 5; beats 0..3 persist.
    for (int k = 0; k < 8; k++) wbuf[k] = 32'hB0 + k;
    a0 = ack_cnt;
    do_write(5, 4, 1'b1, e0);
    @(negedge clk); #1;
    chk("rstwr_ack", ack_cnt - a0, 32'd0);
    rd_log.delete();
    do_read(5, 1'b0, -1, 1'b0, e0);
    @(negedge clk); #1;
    for (int k = 0; k < 4; k++) chk("rstwr_word", (k < rd_log.size()) ? rd_log[k] : 32'hDEAD_BEEF, 32'hB0 + k);

    // Reset in the middle of a read burst.
    do_read(3, 1'b0, L + 3, 1'b1, e0);

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 5);
      r = $urandom_range(0, 8);
      line = (r == 8) ? 63 : r;
      for (int k = 0; k < 8; k++) wbuf[k] = $urandom;
      case (op)
        0, 1: do_write(line, 8, 1'b0, e0);
        2: do_write(line, $urandom_range(0, 7), ($urandom_range(0, 3) == 0), e0);
        3: do_read(line, 1'b0, -1, 1'b0, e0);
        4: do_read(line, 1'b0, $urandom_range(0, L + 7), ($urandom_range(0, 3) == 0), e0);
        default: do_read(line, 1'b1, -1, 1'b0, e0);
      endcase
    end

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/l2_responder.md
# l2_responder

Memory-side responder for the L1-to-L2 request interface driven by the L1 cache controller. It accepts level-held read requests (`read_l2`) and write-buffer requests (`write_l2`) against a line-organised backing store of 8 × 32-bit words per line. Reads return 8 data beats after a programmable latency; writes absorb an 8-beat burst. Every request that completes is closed with a one-cycle `l2_ack` pulse. The block sits between the L1 controller and main memory and serves as the L2 model in the L1 testbench.

## Interface
- READ_LATENCY, 4, number of cycles from read acceptance to the first read beat; legal range ≥1
- LINE_AW, 6, line-index width; the store holds 2^LINE_AW lines
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; resets the control state only, not the store
- read_l2  input  1  read request; the requester holds it high until it sees `l2_ack`
- write_l2  input  1  write request; the requester holds it high through the burst
- addr  input  32  byte address; line index = addr[LINE_AW+4:5]; sampled only at acceptance
- wdata  input  32  write beat data, sampled once per beat
- rdata  output  32  read beat data
- rdata_valid  output  1  high during each of the 8 read-beat cycles
- l2_ack  output  1  one-cycle completion pulse
- busy  output  1  high whenever state ≠ IDLE

## Operation
- **State encoding:** 3 bits. States are IDLE, RD_WAIT, RD_BURST, WR_BURST, ACK, GAP.
- **IDLE:**
  - If `read_l2` is high, latch the line index, clear the latency counter and go to RD_WAIT.
  - Else if `write_l2` is high, latch the line index, clear the beat counter and go to WR_BURST.
  - Read wins when both are high; the write is not recorded.
- **RD_WAIT:**
  - Count READ_LATENCY cycles, then go to RD_BURST with beat counter 0.
  - The latency counter is $clog2(READ_LATENCY+1) bits wide.
- **RD_BURST:**
  - Drive `rdata` = store[line][beat] and `rdata_valid` = 1.
  - The beat counter is 3 bits and increments each cycle.
  - After beat 7 (counter wraps 7→0), go to ACK.
- **WR_BURST:**
  - Each cycle, write `wdata` into store[line][beat] and increment the beat counter.
  - After beat 7, go to ACK.
- **ACK:** `l2_ack` = 1 for exactly one cycle, then go to GAP.
- **GAP:** One cycle in which request inputs are ignored, so the requester can deassert. Then go to IDLE.
- **Abort:**
  - If the active request (`read_l2` in RD_WAIT/RD_BURST, `write_l2` in WR_BURST) is sampled low, go to IDLE.
  - No `l2_ack` is issued.
  - Write beats already stored stay stored.
- **Coherence:** A read of a line returns the data from the most recent completed or partial write to that line.
- **Reset mid-operation:** The block goes to IDLE immediately. No `l2_ack` is issued, and store contents are retained.
- **Store contents:** Undefined after power-up. The bench writes a line before reading it.

## Timing
- **Reset values:** state IDLE, `rdata` 0, `rdata_valid` 0, `l2_ack` 0, `busy` 0, both counters 0.
- **Read timing:** Acceptance edge E0 (IDLE, `read_l2` = 1).
  - RD_WAIT occupies cycles E0+1 … E0+READ_LATENCY.
  - Beat k is valid in cycle E0+READ_LATENCY+1+k, for k = 0..7.
  - `l2_ack` is high in cycle E0+READ_LATENCY+9.
  - GAP is the next cycle; IDLE follows, with acceptance possible at the end of that cycle.
- **Write timing:** Acceptance edge E0 (IDLE, `write_l2` = 1, `read_l2` = 0).
  - Beat k is sampled at edge E0+1+k, for k = 0..7.
  - `l2_ack` is high in cycle E0+9, i.e. the cycle after beat 7 is sampled.
- **`busy`:** High from E0+1 through the GAP cycle inclusive.
- **Output source:** All outputs are decoded from registered state, counters and store. No combinational input-to-output paths.
- **Minimum round trip:**
  - Read: READ_LATENCY+11 cycles from acceptance to next acceptance.
  - Write: 11 cycles.

## Test plan
- **Reset:** Assert `reset` asynchronously between edges → all outputs 0 immediately; `busy` = 0.
- **Write burst:** `write_l2` = 1, addr = 0x60 (line 3), `wdata` 0xA0..0xA7 on beats 0..7 → `l2_ack` high exactly one cycle, in cycle E0+9; `busy` high 10 cycles.
- **Read back (READ_LATENCY = 4):** `read_l2` = 1, addr = 0x60 → `rdata_valid` high in cycles E0+5..E0+12 with `rdata` 0xA0..0xA7; `l2_ack` in cycle E0+13.
- **Simultaneous requests:** `read_l2` = `write_l2` = 1 in IDLE → read burst served. A later read of the write's target line shows it unchanged.
- **Read abort:** Drop `read_l2` during RD_WAIT → IDLE next cycle; no `rdata_valid`, no `l2_ack`.
- **Reset mid-write:** Pulse `reset` during write beat 4 of 0xB0..0xB7 to line 5 → no `l2_ack`; a subsequent read of line 5 returns 0xB0..0xB3 in words 0..3.
